alpha2_3_wb_timeout_bridge: RTL and testbench

// - Registered Wishbone bridge between the Caravel management WB master and the alpha2_3 peripheral wrapper.
// - Re-times every request into a single outstanding downstream transaction.
// - Guarantees an upstream ack for every request. Unmapped addresses or hung slaves are terminated by a

---
 rtl/alpha2_3_wb_timeout_bridge.sv | 165 ++++++++++++++++
 tb/tb_alpha2_3_wb_timeout_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha2_3_wb_timeout_bridge.sv
// Registered Wishbone bridge: one outstanding downstream transfer, timeout abort with ERR_DATA and sticky IRQ.
// Define ALPHA2_3_BRIDGE_CSR_EN to serve a local status/clear register at CSR_ADDR instead of forwarding it.
module alpha2_3_wb_timeout_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
`ifdef ALPHA2_3_BRIDGE_CSR_EN
    ,
    parameter logic [31:0] CSR_ADDR       = 32'h3000_F000
`endif
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_dat_i,
    input  logic        err_clr_i,
    output logic        err_irq_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             req_valid;
    logic             timeout_hit;

    // The master still holds stb during the ack cycle; ignoring it there prevents a duplicate request.
    assign req_valid   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign timeout_hit = (count_reg == CNT_LAST);

`ifdef ALPHA2_3_BRIDGE_CSR_EN
    logic       local_reg;
    logic       csr_clr_reg;
    logic [7:0] err_count_reg;
    logic       csr_hit;

    assign csr_hit = (wbs_adr_i == CSR_ADDR);
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            wbs_ack_o     <= 1'b0;
            wbs_dat_o     <= '0;
            m_cyc_o       <= 1'b0;
            m_stb_o       <= 1'b0;
            m_we_o        <= 1'b0;
            m_sel_o       <= '0;
            m_adr_o       <= '0;
            m_dat_o       <= '0;
            err_irq_o     <= 1'b0;
`ifdef ALPHA2_3_BRIDGE_CSR_EN
            local_reg     <= 1'b0;
            csr_clr_reg   <= 1'b0;
            err_count_reg <= '0;
`endif
        end else begin
            wbs_ack_o <= 1'b0;
            // A timeout later in this block overrides the clear, so set wins.
            if (err_clr_i) begin
                err_irq_o <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        count_reg <= '0;
                        state_reg <= REQ;
`ifdef ALPHA2_3_BRIDGE_CSR_EN
                        local_reg   <= csr_hit;
                        csr_clr_reg <= wbs_we_i & wbs_sel_i[3] & wbs_dat_i[31];
                        if (!csr_hit) begin
                            m_adr_o <= wbs_adr_i;
                            m_dat_o <= wbs_dat_i;
                            m_sel_o <= wbs_sel_i;
                            m_we_o  <= wbs_we_i;
                            m_cyc_o <= 1'b1;
                            m_stb_o <= 1'b1;
                        end
`else
                        m_adr_o <= wbs_adr_i;
                        m_dat_o <= wbs_dat_i;
                        m_sel_o <= wbs_sel_i;
                        m_we_o  <= wbs_we_i;
                        m_cyc_o <= 1'b1;
                        m_stb_o <= 1'b1;
`endif
                    end
                end

                REQ: begin
`ifdef ALPHA2_3_BRIDGE_CSR_EN
                    if (local_reg) begin
                        wbs_dat_o <= {err_irq_o, 7'b0, err_count_reg, 16'b0};
                        if (csr_clr_reg) begin
                            err_irq_o     <= 1'b0;
                            err_count_reg <= '0;
                        end
                        state_reg <= RESP;
                    end else
`endif
                    if (m_ack_i) begin
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        // An ack racing a master abort is dropped: the master no longer wants it.
                        if (wbs_cyc_i) begin
                            wbs_dat_o <= m_dat_i;
                            state_reg <= RESP;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        m_cyc_o   <= 1'b0;
                        m_stb_o   <= 1'b0;
                        wbs_dat_o <= ERR_DATA;
                        err_irq_o <= 1'b1;
`ifdef ALPHA2_3_BRIDGE_CSR_EN
                        if (err_count_reg != 8'hFF) begin
                            err_count_reg <= err_count_reg + 8'd1;
                        end
`endif
                        state_reg <= RESP;
                    end else if (!wbs_cyc_i) begin
                        m_cyc_o   <= 1'b0;
                        m_stb_o   <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end

                RESP: begin
                    wbs_ack_o <= 1'b1;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alpha2_3_wb_timeout_bridge.sv
// Self-checking bench: directed corner cases plus random transactions checked against an outcome-level model.
// Model predicts each transfer's outcome (done/timeout/abort/local) from which event happens first.
module tb_alpha2_3_wb_timeout_bridge;

    localparam int          T        = 16;
    localparam int          LIM      = T + 6;
    localparam logic [31:0] ERR      = 32'hDEAD_BEEF;
    localparam logic [31:0] CSR_ADR  = 32'h3000_F000;
    localparam int          NONE     = 999;

    localparam int O_DONE  = 0;
    localparam int O_TOUT  = 1;
    localparam int O_ABORT = 2;
    localparam int O_LOCAL = 3;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic        m_ack_i;
    logic [31:0] m_dat_i;
    logic        err_clr_i;
    logic        err_irq_o;

    alpha2_3_wb_timeout_bridge #(
        .TIMEOUT_CYCLES(T),
        .ERR_DATA      (ERR)
    ) u_dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_stb_i(wbs_stb_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .m_cyc_o  (m_cyc_o),
        .m_stb_o  (m_stb_o),
        .m_we_o   (m_we_o),
        .m_sel_o  (m_sel_o),
        .m_adr_o  (m_adr_o),
        .m_dat_o  (m_dat_o),
        .m_ack_i  (m_ack_i),
        .m_dat_i  (m_dat_i),
        .err_clr_i(err_clr_i),
        .err_irq_o(err_irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          checks = 0;
    int          errors = 0;
    int          txn_no = 0;
    logic        model_irq;
    int          model_cnt;
    logic [31:0] model_dat;
    bit          dat_known;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ack_at / abort_at / clr_at are REQ-cycle indices (0 = first cycle after sampling); NONE disables.
    task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int ack_at, input int abort_at,
                          input int clr_at, input logic [31:0] sdat);
        int          outcome, e, ack_cnt, ack_edge, mcyc_cnt, exp_edge, exp_mcyc;
        bit          drive_req, drop_next, local_hit;
        logic [31:0] csr_val;
        string       oname;

        local_hit = 1'b0;
        csr_val   = '0;
`ifdef ALPHA2_3_BRIDGE_CSR_EN
        local_hit = (adr == CSR_ADR);
        csr_val   = {model_irq, 7'b0, 8'(model_cnt), 16'b0};
`endif
        // Whichever of ack, abort, timeout comes first decides the outcome.
        e = T - 1;
        if (ack_at < e)   e = ack_at;
        if (abort_at < e) e = abort_at;
        if (local_hit)          outcome = O_LOCAL;
        else if (ack_at == e)   outcome = (abort_at <= e) ? O_ABORT : O_DONE;
        else if (e == T - 1)    outcome = O_TOUT;
        else                    outcome = O_ABORT;

        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        m_ack_i   = 1'b0;
        err_clr_i = 1'b0;
        @(posedge wb_clk_i); #1;
        if (local_hit) begin
            check_eq("csr_no_fwd", 32'(m_cyc_o), 32'd0);
        end else begin
            check_eq("fwd_cyc", 32'(m_cyc_o), 32'd1);
            check_eq("fwd_stb", 32'(m_stb_o), 32'd1);
            check_eq("fwd_adr", m_adr_o, adr);
            check_eq("fwd_dat", m_dat_o, dat);
            check_eq("fwd_sel", 32'(m_sel_o), 32'(sel));
            check_eq("fwd_we", 32'(m_we_o), 32'(we));
        end
        mcyc_cnt  = m_cyc_o ? 1 : 0;
        ack_cnt   = 0;
        ack_edge  = -1;
        drive_req = 1'b1;
        drop_next = 1'b0;
        for (int c = 1; c <= LIM; c++) begin
            if (c - 1 == abort_at) drive_req = 1'b0;
            wbs_cyc_i = drive_req;
            wbs_stb_i = drive_req;
            m_ack_i   = m_cyc_o && (c - 1 == ack_at);
            m_dat_i   = m_ack_i ? sdat : $urandom;
            err_clr_i = (c - 1 == clr_at);
            @(posedge wb_clk_i); #1;
            if (drop_next) drive_req = 1'b0;
            if (wbs_ack_o) begin
                ack_cnt++;
                if (ack_edge < 0) ack_edge = c;
                drop_next = 1'b1;
            end
            if (m_cyc_o) mcyc_cnt++;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        m_ack_i   = 1'b0;
        err_clr_i = 1'b0;

        exp_edge = -1;
        exp_mcyc = 0;
        case (outcome)
            O_DONE: begin
                oname    = "done";
                exp_edge = ack_at + 2;
                exp_mcyc = ack_at + 1;
                if (!we) begin model_dat = sdat; dat_known = 1'b1; end
                else dat_known = 1'b0;
            end
            O_TOUT: begin
                oname     = "timeout";
                exp_edge  = T + 1;
                exp_mcyc  = T;
                model_dat = ERR;
                dat_known = 1'b1;
                if (model_cnt < 255) model_cnt++;
            end
            O_ABORT: begin
                oname    = "abort";
                exp_mcyc = e + 1;
            end
            default: begin
                oname    = "local";
                exp_edge = 2;
                if (!we) begin model_dat = csr_val; dat_known = 1'b1; end
                else dat_known = 1'b0;
                if (we && sel[3] && dat[31]) begin model_irq = 1'b0; model_cnt = 0; end
            end
        endcase
        if (outcome == O_TOUT) model_irq = (clr_at >= T && clr_at < LIM) ? 1'b0 : 1'b1;
        else if (clr_at < LIM) model_irq = 1'b0;

        check_eq("ack_count", 32'(ack_cnt), (exp_edge < 0) ? 32'd0 : 32'd1);
        if (exp_edge >= 0) check_eq("ack_latency", 32'(ack_edge), 32'(exp_edge));
        check_eq("m_cyc_cycles", 32'(mcyc_cnt), 32'(exp_mcyc));
        check_eq("err_irq", 32'(err_irq_o), 32'(model_irq));
        if (dat_known) check_eq("rd_data", wbs_dat_o, model_dat);
        $display("txn %0d: we=%0d adr=%08h outcome=%s ack_edge=%0d m_cyc_cycles=%0d dat=%08h irq=%0d",
                 txn_no, we, adr, oname, ack_edge, mcyc_cnt, wbs_dat_o, err_irq_o);
        txn_no++;
    endtask

    initial begin
        int          r, ack_at, abort_at, clr_at;
        logic [31:0] adr;

        wb_rst_n  = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0;   wbs_adr_i = '0;   wbs_dat_i = '0;
        m_ack_i   = 1'b0; m_dat_i   = '0;   err_clr_i = 1'b0;
        model_irq = 1'b0; model_cnt = 0;    model_dat = '0; dat_known = 1'b1;

        #1;
        check_eq("rst_ack", 32'(wbs_ack_o), 32'd0);
        check_eq("rst_dat", wbs_dat_o, 32'd0);
        check_eq("rst_m_cyc", 32'(m_cyc_o), 32'd0);
        check_eq("rst_m_stb", 32'(m_stb_o), 32'd0);
        check_eq("rst_m_we", 32'(m_we_o), 32'd0);
        check_eq("rst_m_sel", 32'(m_sel_o), 32'd0);
        check_eq("rst_m_adr", m_adr_o, 32'd0);
        check_eq("rst_m_dat", m_dat_o, 32'd0);
        check_eq("rst_irq", 32'(err_irq_o), 32'd0);
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        @(posedge wb_clk_i); #1;

        // Directed corner cases.
        do_txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, NONE, NONE, 32'h1234_5678);
        do_txn(1'b1, 32'h3000_3000, 32'hA5A5_A5A5, 4'b0011, 2, NONE, NONE, 32'h0);
        do_txn(1'b0, 32'h3000_9000, 32'h0, 4'hF, NONE, NONE, NONE, 32'h0);
        do_txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, T - 1, NONE, 0, 32'hCAFE_0001);
        do_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, NONE, 2, NONE, 32'h0);
        do_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, NONE, NONE, T - 1, 32'h0);
        do_txn(1'b0, 32'h3000_0040, 32'h0, 4'hF, 3, NONE, 5, 32'h0BAD_F00D);
        do_txn(1'b0, 32'h3000_0050, 32'h0, 4'hF, 4, 4, NONE, 32'h7777_7777);

        // Reset in the middle of a transfer must drop m_cyc at once and produce no ack.
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0060;
        repeat (3) @(posedge wb_clk_i);
        #3;
        wb_rst_n = 1'b0;
        #1;
        check_eq("midrst_m_cyc", 32'(m_cyc_o), 32'd0);
        check_eq("midrst_ack", 32'(wbs_ack_o), 32'd0);
        check_eq("midrst_irq", 32'(err_irq_o), 32'd0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_n  = 1'b1;
        model_irq = 1'b0; model_cnt = 0; model_dat = '0; dat_known = 1'b1;
        r = 0;
        repeat (4) begin
            @(posedge wb_clk_i); #1;
            if (wbs_ack_o || m_cyc_o) r++;
        end
        check_eq("midrst_quiet", 32'(r), 32'd0);

`ifdef ALPHA2_3_BRIDGE_CSR_EN
        do_txn(1'b0, 32'h3000_9000, 32'h0, 4'hF, NONE, NONE, NONE, 32'h0);
        do_txn(1'b0, 32'h3000_9004, 32'h0, 4'hF, NONE, NONE, NONE, 32'h0);
        do_txn(1'b0, CSR_ADR, 32'h0, 4'hF, NONE, NONE, NONE, 32'h0);
        check_eq("csr_rd_2err", wbs_dat_o, 32'h8002_0000);
        do_txn(1'b1, CSR_ADR, 32'h8000_0000, 4'b1000, NONE, NONE, NONE, 32'h0);
        do_txn(1'b0, CSR_ADR, 32'h0, 4'hF, NONE, NONE, NONE, 32'h0);
        check_eq("csr_rd_clr", wbs_dat_o, 32'h0);
`endif

        // Random traffic: mix of normal acks, timeouts and master aborts.
        for (int n = 0; n < 40; n++) begin
            r        = $urandom_range(0, 9);
            abort_at = NONE;
            if (r < 6) begin
                ack_at = $urandom_range(0, T - 1);
            end else if (r < 8) begin
                ack_at = NONE;
            end else begin
                ack_at   = $urandom_range(0, T + 2);
                abort_at = $urandom_range(0, T - 2);
            end
            clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LIM - 1) : NONE;
            adr    = 32'h3000_0000 | (32'($urandom_range(0, 14)) << 12) | ($urandom & 32'h0000_0FFC);
            do_txn(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom_range(1, 15)),
                   ack_at, abort_at, clr_at, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
